// File: rtl/scan_enc_pkg.sv
// Shared types and helpers for the scan encoder: FSM state encoding and
// the index-width rule used by the top and the priority finder.
package scan_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width is never narrower than one bit, even for N=2.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/find_first_set.sv
// Combinational priority finder: locates the lowest or highest set bit of a
// vector and flags whether that bit is the only one set.
module find_first_set
    import scan_enc_pkg::*;
#(
    parameter  int N         = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int W         = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         single
);

    logic [N-1:0] w_vm1;

    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++)
                if (vec[i]) idx = W'(i);
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (vec[i]) idx = W'(i);
        end
    end

    // A vector has exactly one bit set when clearing its lowest set bit leaves zero.
    assign w_vm1  = vec - N'(1);
    assign found  = |vec;
    assign single = found && ((vec & w_vm1) == '0);

endmodule

// File: rtl/scan_encoder.sv
// Accepts an N-bit request vector and emits the index of every set bit, one
// beat per cycle, in ascending or descending order; an all-zero vector
// produces a single error beat.
module scan_encoder
    import scan_enc_pkg::*;
#(
    parameter  int N         = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int W         = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [N-1:0] in_vec,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_err,
    output logic         busy
);

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_pend,  w_pend_nxt;
    logic         r_zero,  w_zero_nxt;

    logic [W-1:0] w_idx;
    logic         w_found;
    logic         w_single;
    logic         w_scan;
    logic         w_last;
    logic [N-1:0] w_clr;

    find_first_set #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_ffs (
        .vec    (r_pend),
        .idx    (w_idx),
        .found  (w_found),
        .single (w_single)
    );

    assign w_scan = (r_state == SCAN);
    // A zero vector is held as an empty pending register plus r_zero.
    assign w_last = w_scan && (w_single || r_zero);
    assign w_clr  = N'(1) << w_idx;

    assign in_ready  = en && (r_state == IDLE);
    assign out_valid = w_scan;
    assign out_idx   = (w_scan && w_found) ? w_idx : '0;
    assign out_last  = w_last;
    assign out_err   = w_scan && r_zero;
    assign busy      = w_scan;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_zero_nxt  = r_zero;
        case (r_state)
            IDLE: begin
                if (in_valid && en) begin
                    w_state_nxt = SCAN;
                    w_pend_nxt  = in_vec;
                    w_zero_nxt  = (in_vec == '0);
                end
            end
            SCAN: begin
                if (out_ready) begin
                    w_pend_nxt = r_pend & ~w_clr;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_pend_nxt  = '0;
                        w_zero_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = '0;
                w_zero_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

endmodule

// File: tb/tb_scan_encoder.sv
// Bench for scan_encoder: LSB-first and MSB-first instances driven in lockstep
// and compared every cycle against a queue-based model of the index stream.
module tb_scan_encoder;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_vec = '0;
    logic         out_ready = 1'b0;

    logic         rdy0, vld0, last0, err0, busy0;
    logic [W-1:0] idx0;
    logic         rdy1, vld1, last1, err1, busy1;
    logic [W-1:0] idx1;

    scan_encoder #(.N(N), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_vec(in_vec),
        .in_ready(rdy0), .out_valid(vld0), .out_ready(out_ready), .out_idx(idx0),
        .out_last(last0), .out_err(err0), .busy(busy0)
    );

    scan_encoder #(.N(N), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_vec(in_vec),
        .in_ready(rdy1), .out_valid(vld1), .out_ready(out_ready), .out_idx(idx1),
        .out_last(last1), .out_err(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: remaining set-bit indices in ascending order; LSB-first consumes
    // from the front, MSB-first from the back.
    int qa[$];
    int qd[$];
    bit m_scan = 1'b0;
    bit m_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 1'b0;
        m_err  = 1'b0;
        qa.delete();
        qd.delete();
    endtask

    task automatic check_outs();
        int  e0, e1;
        bit  l0, l1;
        e0 = 0; e1 = 0; l0 = 0; l1 = 0;
        if (m_scan) begin
            if (!m_err) begin
                e0 = qa[0];
                e1 = qd[qd.size()-1];
            end
            l0 = m_err || (qa.size() == 1);
            l1 = m_err || (qd.size() == 1);
        end
        chk("rdy0",  64'(rdy0),  64'(en && !m_scan));
        chk("rdy1",  64'(rdy1),  64'(en && !m_scan));
        chk("vld0",  64'(vld0),  64'(m_scan));
        chk("vld1",  64'(vld1),  64'(m_scan));
        chk("busy0", 64'(busy0), 64'(m_scan));
        chk("busy1", 64'(busy1), 64'(m_scan));
        chk("idx0",  64'(idx0),  64'(e0));
        chk("idx1",  64'(idx1),  64'(e1));
        chk("last0", 64'(last0), 64'(l0));
        chk("last1", 64'(last1), 64'(l1));
        chk("err0",  64'(err0),  64'(m_scan && m_err));
        chk("err1",  64'(err1),  64'(m_scan && m_err));
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model
    // to what the next rising edge should do.
    task automatic cyc(input bit iv, input logic [N-1:0] vec, input bit e, input bit ordy);
        @(negedge clk);
        in_valid  = iv;
        in_vec    = vec;
        en        = e;
        out_ready = ordy;
        #1;
        check_outs();
        if (m_scan) begin
            if (ordy) begin
                if (m_err || qa.size() == 1) model_reset();
                else begin
                    void'(qa.pop_front());
                    void'(qd.pop_back());
                end
            end
        end else if (iv && e) begin
            m_scan = 1'b1;
            m_err  = (vec == '0);
            for (int i = 0; i < N; i++)
                if (vec[i]) begin
                    qa.push_back(i);
                    qd.push_back(i);
                end
        end
    endtask

    initial begin
        logic [N-1:0] v;
        int           sel;

        // Outputs in reset
        #1;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;

        // 0xA4 with continuous out_ready: LSB 2,5,7 / MSB 7,5,2
        cyc(1, 8'hA4, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);

        // Zero vector: single error beat
        cyc(1, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);

        // 0x81 with three stalled cycles
        cyc(1, 8'h81, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 1);

        // Back-to-back offer: no acceptance in the cycle the last beat is taken
        cyc(1, 8'h06, 1, 1);
        cyc(1, 8'h18, 1, 1);
        cyc(1, 8'h18, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);

        // 0xFF, asynchronous reset after the third beat
        cyc(1, 8'hFF, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        @(posedge clk);
        #2;
        chk("busy_pre_rst", 64'(busy0), 64'(m_scan));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_vld0",  64'(vld0),  64'd0);
        chk("rst_vld1",  64'(vld1),  64'd0);
        chk("rst_idx0",  64'(idx0),  64'd0);
        chk("rst_idx1",  64'(idx1),  64'd0);
        chk("rst_last0", 64'(last0), 64'd0);
        chk("rst_err0",  64'(err0),  64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 1);

        // en=0 blocks acceptance for five cycles, then 0x10 is taken
        for (int i = 0; i < 5; i++) cyc(1, 8'h10, 0, 1);
        cyc(1, 8'h10, 1, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0)      v = '0;
            else if (sel == 1) v = N'(1) << $urandom_range(0, N-1);
            else               v = N'($urandom);
            cyc($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0);
        end

        // Drain
        for (int i = 0; i < N + 2; i++) cyc(0, 8'h00, 1, 1);
        chk("drained", 64'(busy0 | busy1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scan_encoder.md
SCAN_ENCODER -- requirements
Module: scan_encoder

Interface
REQ-001 Parameter N, default 8, SHALL set the input vector width; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0, SHALL select scan order: 0 = lowest set bit first, 1 = highest set bit first.
REQ-003 Localparam W = max(1, ceil(log2(N))) SHALL set the index width and SHALL NOT be overridable.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  acceptance enable; 0 blocks new vectors only.
REQ-007 in_valid  input  1  in_vec is offered this cycle.
REQ-008 in_vec  input  N  request vector, one bit per source.
REQ-009 in_ready  output  1  block can accept in_vec this cycle.
REQ-010 out_valid  output  1  out_idx, out_last and out_err are valid.
REQ-011 out_ready  input  1  consumer takes the current beat.
REQ-012 out_idx  output  W  binary index of the current set bit.
REQ-013 out_last  output  1  current beat is the final one for this vector.
REQ-014 out_err  output  1  accepted vector had no bits set.
REQ-015 busy  output  1  a vector is held and not yet fully emitted.

Function
REQ-016 The block SHALL have states IDLE and SCAN.
REQ-017 in_ready SHALL equal en AND (state == IDLE); in_ready SHALL NOT depend on in_valid.
REQ-018 Acceptance occurs when in_valid && in_ready at a rising edge; in_vec is then copied to an N-bit pending register and the state SHALL move to SCAN.
REQ-019 In SCAN, out_valid SHALL be 1; out_idx SHALL be the index of the lowest set bit of pending (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1).
REQ-020 The first out_valid SHALL occur in the cycle after acceptance (latency 1); out_* SHALL be combinational from registered state only.
REQ-021 out_last SHALL be 1 when pending holds exactly one set bit.
REQ-022 On out_valid && out_ready, the bit at out_idx SHALL clear in pending; if out_last, the state SHALL return to IDLE; otherwise the next beat follows the next cycle.
REQ-023 While out_valid && !out_ready, out_idx, out_last, out_err and pending SHALL hold stable.
REQ-024 A zero vector SHALL be accepted and produce exactly one beat: out_idx=0, out_last=1, out_err=1; out_err SHALL be 0 on every other beat.
REQ-025 A vector with k set bits (k>=1) SHALL produce exactly k beats with strictly ascending (MSB_FIRST=0) or descending (MSB_FIRST=1) indices; throughput is one beat per cycle under continuous out_ready.
REQ-026 en deasserting during SCAN SHALL NOT stall or abort emission.
REQ-027 A new vector SHALL NOT be accepted in the same cycle the last beat is taken; earliest acceptance is the following cycle.
REQ-028 busy SHALL equal (state == SCAN).
REQ-029 In IDLE, out_valid, out_last and out_err SHALL be 0, and out_idx SHALL be 0.

Reset
REQ-030 When rst_n is 0, state SHALL be IDLE, pending SHALL be 0, and out_valid/out_last/out_err/busy/out_idx SHALL be 0 immediately, without waiting for clk.
REQ-031 Reset asserted mid-SCAN SHALL discard the remaining bits; after release, no stale beat SHALL appear and in_ready SHALL follow en on the first cycle.

Structure
REQ-032 The package scan_enc_pkg SHALL hold the state typedef (IDLE, SCAN) and the index-width function.
REQ-033 A combinational sub-module find_first_set (parameters N, MSB_FIRST; outputs idx, found, single) SHALL compute out_idx and out_last from pending.

Verification (N=8)
REQ-034 MSB_FIRST=0, in_vec=8'b1010_0100, out_ready=1 -> idx 2,5,7 on three consecutive cycles starting one cycle after acceptance; out_last=1 only with idx 7; in_ready=1 on the cycle after that.
REQ-035 MSB_FIRST=1, same vector -> idx 7,5,2; out_last=1 only with idx 2.
REQ-036 in_vec=8'h00 -> single beat idx=0, out_last=1, out_err=1; then IDLE.
REQ-037 in_vec=8'h81, out_ready held 0 for 3 cycles -> idx=0 held stable with out_last=0; after release, idx 0 then idx 7 (out_last=1).
REQ-038 in_vec=8'hFF, rst_n pulsed low after the 3rd beat -> outputs 0 asynchronously; after release, no beats and in_ready=en.
REQ-039 en=0 with in_valid=1, in_vec=8'h10 for 5 cycles -> in_ready=0 and no beats; en=1 -> accepted, idx 4 with out_last=1.
